regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 86 ++++++++
 rtl/regwb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regwb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// -----------------------------------------------------------------------------
// regwb_pkg -- shared constants and types for the register write-back arbiter.
//
// Contents:
//   NREQ         number of write-back requesters (ALU, MEM, IMM, IO)
//   SELW         width of the register-input mux select code
//   SEL_*        mux select codes driven onto wb_sel
//   wb_state_e   output-stage state (EMPTY / FULL)
//   req_to_sel() requester index -> mux select code
// -----------------------------------------------------------------------------
package regwb_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 4;
  localparam int IDXW = 2;

  localparam logic [SELW-1:0] SEL_ALU = 4'd0;
  localparam logic [SELW-1:0] SEL_MEM = 4'd1;
  localparam logic [SELW-1:0] SEL_IMM = 4'd2;
  localparam logic [SELW-1:0] SEL_IO  = 4'd7;
  localparam logic [SELW-1:0] SEL_PC  = 4'd6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_e;

  // Requester 3 (IO) is not contiguous with the others in the mux encoding.
  function automatic logic [SELW-1:0] req_to_sel(input logic [IDXW-1:0] idx);
    logic [SELW-1:0] sel;
    case (idx)
      2'd0:    sel = SEL_ALU;
      2'd1:    sel = SEL_MEM;
      2'd2:    sel = SEL_IMM;
      default: sel = SEL_IO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter -- combinational requester selection for the write-back port.
//
// Build option:
//   REGWB_RR_EN defined   : round-robin; search starts at a pointer which moves
//                           to (winner+1) mod NREQ on every accept.
//   REGWB_RR_EN undefined : fixed priority, requester 0 highest; no pointer.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset (pointer only)
//   req_i        per-requester valid
//   advance_i    a grant was accepted this cycle
//   grant_o      one-hot winner (0 when no request)
//   grant_idx_o  binary index of the winner
//   grant_any_o  at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import regwb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            grant_any_o
);

`ifdef REGWB_RR_EN

  logic [IDXW-1:0] ptr_q, ptr_d;

  // Masked priority encoder: walk the requesters starting at the pointer; the
  // 2-bit index wraps naturally so 3 is followed by 0.
  always_comb begin
    logic [IDXW-1:0] idx;
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + IDXW'(k);
      if (!grant_any_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        grant_any_o  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = grant_idx_o + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`else

  // Fixed priority: lowest index wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any_o && req_i[k]) begin
        grant_o[k]  = 1'b1;
        grant_idx_o = IDXW'(k);
        grant_any_o = 1'b1;
      end
    end
  end

  // Clock, reset and advance have no function without a pointer.
  logic unused_fixed_prio;
  assign unused_fixed_prio = clk ^ rst_n ^ advance_i;

`endif

endmodule

// File: rtl/regwb_arbiter.sv
// -----------------------------------------------------------------------------
// regwb_arbiter -- arbitrates four register-file write-back requesters (ALU,
// MEM, IMM, IO) onto a single registered write port.
//
// Build option: REGWB_RR_EN selects round-robin arbitration (default: fixed
// priority, requester 0 highest).
//
// Parameters:
//   AW        register address width
//   IDLE_SEL  wb_sel value while no write is pending
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   req_valid    per-requester write request (bit0 ALU .. bit3 IO)
//   req_addr     destination register, slice i belongs to requester i
//   req_ready    per-requester accept, one-hot or zero
//   wb_ready     register-file write port accepts this cycle
//   wb_valid     registered write pending
//   wb_sel       register-input data mux select
//   wb_addr      destination register of the pending write
//   wb_src       one-hot owner of the pending write
// -----------------------------------------------------------------------------
module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int              AW       = 4,
  parameter logic [SELW-1:0] IDLE_SEL = 4'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_ready,
  output logic               wb_valid,
  output logic [SELW-1:0]    wb_sel,
  output logic [AW-1:0]      wb_addr,
  output logic [NREQ-1:0]    wb_src
);

  wb_state_e       state_q, state_d;
  logic [SELW-1:0] sel_q,   sel_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [NREQ-1:0] src_q,   src_d;

  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_any;
  logic            can_accept;
  logic            accept;
  logic            accept_wr;
  logic [AW-1:0]   win_addr;

  rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // The output stage can take a new write when it is empty or draining.
  assign can_accept = (state_q == EMPTY) || wb_ready;

  // Gating with rst_n keeps every ready low throughout reset, not only after
  // the first edge.
  assign req_ready = (rst_n && can_accept) ? grant : '0;
  assign accept    = rst_n && can_accept && grant_any;

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win_addr = req_addr[i*AW +: AW];
    end
  end

  // Register 0 is hardwired: such a request is consumed but never written.
  assign accept_wr = accept && (win_addr != '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    src_d   = src_q;
    case (state_q)
      EMPTY: begin
        if (accept_wr) begin
          state_d = FULL;
          sel_d   = req_to_sel(grant_idx);
          addr_d  = win_addr;
          src_d   = grant;
        end
      end
      FULL: begin
        if (wb_ready) begin
          if (accept_wr) begin
            sel_d  = req_to_sel(grant_idx);
            addr_d = win_addr;
            src_d  = grant;
          end else begin
            state_d = EMPTY;
            sel_d   = IDLE_SEL;
            addr_d  = '0;
            src_d   = '0;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        sel_d   = IDLE_SEL;
        addr_d  = '0;
        src_d   = '0;
      end
    endcase
  end

  // NOTE: every output-stage register has an explicit reset value so a write
  // pending when reset arrives is dropped immediately, not at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sel_q   <= IDLE_SEL;
      addr_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
    end
  end

  assign wb_valid = (state_q == FULL);
  assign wb_sel   = sel_q;
  assign wb_addr  = addr_q;
  assign wb_src   = src_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regwb_arbiter -- self-checking bench for regwb_arbiter. A transaction-level
// model (one pending-write slot, a pointer integer, a code table) predicts
// req_ready and wb_* every cycle; directed scenarios add literal expectations.
// Honours REGWB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regwb_arbiter;

  localparam int         AW       = 4;
  localparam logic [3:0] IDLE_SEL = 4'd6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [4*AW-1:0] req_addr;
  logic [3:0]    req_ready;
  logic          wb_ready;
  logic          wb_valid;
  logic [3:0]    wb_sel;
  logic [AW-1:0] wb_addr;
  logic [3:0]    wb_src;

  regwb_arbiter #(.AW(AW), .IDLE_SEL(IDLE_SEL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .wb_ready  (wb_ready),
    .wb_valid  (wb_valid),
    .wb_sel    (wb_sel),
    .wb_addr   (wb_addr),
    .wb_src    (wb_src)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state.
  bit         m_pend;
  logic [3:0] m_sel;
  logic [3:0] m_addr;
  logic [3:0] m_src;
  int         m_ptr;
  int         code_tab [4] = '{0, 1, 2, 7};

`ifdef REGWB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int model_winner(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = RR ? (m_ptr + k) % 4 : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_sel = IDLE_SEL; m_addr = 0; m_src = 0; m_ptr = 0;
  endtask

  task automatic check_wb();
    check("wb_valid", wb_valid, m_pend);
    check("wb_sel",   wb_sel,   m_pend ? m_sel  : IDLE_SEL);
    check("wb_addr",  wb_addr,  m_pend ? m_addr : 4'd0);
    check("wb_src",   wb_src,   m_pend ? m_src  : 4'd0);
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
  endtask

  // One cycle: called in the low phase with inputs already driven. Checks
  // req_ready, advances the model across the edge, then checks wb_* at negedge.
  task automatic step(output int acc);
    bit         can;
    int         w;
    logic [3:0] exp_rdy;
    logic [3:0] a;
    #1;
    can = !m_pend || wb_ready;
    w = model_winner(req_valid);
    exp_rdy = (can && w >= 0) ? 4'(1 << w) : 4'b0;
    check("req_ready", req_ready, exp_rdy);
    acc = (can && w >= 0) ? w : -1;
    @(posedge clk);
    if (acc >= 0) begin
      a = req_addr[acc*AW +: AW];
      if (a != 0) begin
        m_pend = 1; m_sel = 4'(code_tab[acc]); m_addr = a; m_src = 4'(1 << acc);
      end else begin
        m_pend = 0;
      end
      m_ptr = (acc + 1) % 4;
    end else if (m_pend && wb_ready) begin
      m_pend = 0;
    end
    @(negedge clk);
    check_wb();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; wb_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("reset req_ready", req_ready, 4'b0);
    check_wb();
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int exp_g [5];
    do_reset();
    check("reset wb_sel literal", wb_sel, 32'd6);

    // Zero-address accept while empty: consumed, no write, pointer advances.
    set_req(2, 1, 4'd0);
    #1 check("zero-addr ready", req_ready, 4'b0100);
    step(acc);
    check("zero-addr no write", wb_valid, 1'b0);
    set_req(2, 0, 0);
    for (int i = 0; i < 4; i++) set_req(i, 1, 4'(i + 1));
    wb_ready = 1'b1;
    #1 check("ptr after zero-addr", req_ready, RR ? 4'b1000 : 4'b0001);
    step(acc);

    // All four requesting continuously with distinct addresses.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1, 4'(i + 1));
    wb_ready = 1'b1;
    exp_g = RR ? '{0, 1, 2, 3, 0} : '{0, 0, 0, 0, 0};
    for (int c = 0; c < 5; c++) begin
      #1 check("all-req grant", req_ready, 4'(1 << exp_g[c]));
      step(acc);
      check("all-req wb_sel", wb_sel, code_tab[exp_g[c]]);
    end

    // Stall while full.
    do_reset();
    set_req(1, 1, 4'd3);
    wb_ready = 1'b1;
    step(acc);
    set_req(1, 0, 0);
    set_req(0, 1, 4'd6);
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check("stall ready", req_ready, 4'b0);
      step(acc);
      check("stall wb_sel", wb_sel, 32'd1);
      check("stall wb_addr", wb_addr, 32'd3);
    end
    wb_ready = 1'b1;
    #1 check("unstall ready", req_ready, 4'b0001);
    step(acc);
    check("unstall wb_valid", wb_valid, 1'b1);
    check("unstall wb_addr", wb_addr, 32'd6);
    check("unstall wb_sel", wb_sel, 32'd0);

    // Asynchronous reset with a write pending.
    do_reset();
    set_req(3, 1, 4'd5);
    step(acc);
    check("pre-reset wb_sel", wb_sel, 32'd7);
    check("pre-reset wb_addr", wb_addr, 32'd5);
    set_req(3, 0, 0);
    set_req(0, 1, 4'd2);
    wb_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst wb_valid", wb_valid, 1'b0);
    check("async rst wb_sel", wb_sel, IDLE_SEL);
    check("async rst wb_addr", wb_addr, 4'd0);
    check("async rst wb_src", wb_src, 4'd0);
    check("async rst req_ready", req_ready, 4'b0);
    @(negedge clk);
    model_reset();
    req_valid = '0; req_addr = '0;
    rst_n = 1'b1;

    // Randomised traffic; requesters hold until accepted.
    acc = -1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i]) begin
          if (acc == i) begin
            if ($urandom_range(1) == 0) set_req(i, 0, 0);
            else                        set_req(i, 1, 4'($urandom_range(15)));
          end
        end else if ($urandom_range(1) == 1) begin
          set_req(i, 1, 4'($urandom_range(15)));
        end
      end
      wb_ready = ($urandom_range(9) < 7);
      step(acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
